// File: rtl/mem_port_arbiter.sv
// Two-master to one-slave AXI4 arbiter for the shared DDR port.
// Round-robin AR/AW arbitration with grant locking, an AW-ordered W FIFO and ID-MSB response routing.
module mem_port_arbiter #(
  parameter int unsigned MAX_W_TRANS = 2,
  parameter int unsigned FIX_PRIO    = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_s0_ar_valid,
  output logic        o_s0_ar_ready,
  input  logic [3:0]  i_s0_ar_id,
  input  logic [31:0] i_s0_ar_addr,
  input  logic [7:0]  i_s0_ar_len,
  input  logic [2:0]  i_s0_ar_size,
  input  logic [1:0]  i_s0_ar_burst,
  input  logic        i_s0_aw_valid,
  output logic        o_s0_aw_ready,
  input  logic [3:0]  i_s0_aw_id,
  input  logic [31:0] i_s0_aw_addr,
  input  logic [7:0]  i_s0_aw_len,
  input  logic [2:0]  i_s0_aw_size,
  input  logic [1:0]  i_s0_aw_burst,
  input  logic        i_s0_w_valid,
  output logic        o_s0_w_ready,
  input  logic [31:0] i_s0_w_data,
  input  logic [3:0]  i_s0_w_strb,
  input  logic        i_s0_w_last,
  output logic        o_s0_b_valid,
  input  logic        i_s0_b_ready,
  output logic [3:0]  o_s0_b_id,
  output logic [1:0]  o_s0_b_resp,
  output logic        o_s0_r_valid,
  input  logic        i_s0_r_ready,
  output logic [3:0]  o_s0_r_id,
  output logic [31:0] o_s0_r_data,
  output logic [1:0]  o_s0_r_resp,
  output logic        o_s0_r_last,
  input  logic        i_s1_ar_valid,
  output logic        o_s1_ar_ready,
  input  logic [3:0]  i_s1_ar_id,
  input  logic [31:0] i_s1_ar_addr,
  input  logic [7:0]  i_s1_ar_len,
  input  logic [2:0]  i_s1_ar_size,
  input  logic [1:0]  i_s1_ar_burst,
  input  logic        i_s1_aw_valid,
  output logic        o_s1_aw_ready,
  input  logic [3:0]  i_s1_aw_id,
  input  logic [31:0] i_s1_aw_addr,
  input  logic [7:0]  i_s1_aw_len,
  input  logic [2:0]  i_s1_aw_size,
  input  logic [1:0]  i_s1_aw_burst,
  input  logic        i_s1_w_valid,
  output logic        o_s1_w_ready,
  input  logic [31:0] i_s1_w_data,
  input  logic [3:0]  i_s1_w_strb,
  input  logic        i_s1_w_last,
  output logic        o_s1_b_valid,
  input  logic        i_s1_b_ready,
  output logic [3:0]  o_s1_b_id,
  output logic [1:0]  o_s1_b_resp,
  output logic        o_s1_r_valid,
  input  logic        i_s1_r_ready,
  output logic [3:0]  o_s1_r_id,
  output logic [31:0] o_s1_r_data,
  output logic [1:0]  o_s1_r_resp,
  output logic        o_s1_r_last,
  output logic        o_m_ar_valid,
  input  logic        i_m_ar_ready,
  output logic [4:0]  o_m_ar_id,
  output logic [31:0] o_m_ar_addr,
  output logic [7:0]  o_m_ar_len,
  output logic [2:0]  o_m_ar_size,
  output logic [1:0]  o_m_ar_burst,
  output logic        o_m_aw_valid,
  input  logic        i_m_aw_ready,
  output logic [4:0]  o_m_aw_id,
  output logic [31:0] o_m_aw_addr,
  output logic [7:0]  o_m_aw_len,
  output logic [2:0]  o_m_aw_size,
  output logic [1:0]  o_m_aw_burst,
  output logic        o_m_w_valid,
  input  logic        i_m_w_ready,
  output logic [31:0] o_m_w_data,
  output logic [3:0]  o_m_w_strb,
  output logic        o_m_w_last,
  input  logic        i_m_b_valid,
  output logic        o_m_b_ready,
  input  logic [4:0]  i_m_b_id,
  input  logic [1:0]  i_m_b_resp,
  input  logic        i_m_r_valid,
  output logic        o_m_r_ready,
  input  logic [4:0]  i_m_r_id,
  input  logic [31:0] i_m_r_data,
  input  logic [1:0]  i_m_r_resp,
  input  logic        i_m_r_last
);

  localparam int unsigned PTR_W = (MAX_W_TRANS > 1) ? $clog2(MAX_W_TRANS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_W_TRANS + 1);

  logic r_ar_lock, r_ar_lock_idx, r_ar_last;
  logic r_aw_lock, r_aw_lock_idx, r_aw_last;
  logic [MAX_W_TRANS-1:0] r_wq;
  logic [PTR_W-1:0]       r_wq_wp, r_wq_rp;
  logic [CNT_W-1:0]       r_w_cnt;

  logic w_ar_sel, w_ar_valid, w_ar_hs;
  logic w_aw_sel, w_aw_ok, w_aw_valid, w_aw_hs;
  logic w_wq_nempty, w_head, w_w_hs, w_pop;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_W_TRANS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Winner selection: locked grant, else sole requester, else tie-break
  always_comb begin
    w_ar_sel = 1'b0;
    if (r_ar_lock)                           w_ar_sel = r_ar_lock_idx;
    else if (i_s0_ar_valid && i_s1_ar_valid) w_ar_sel = (FIX_PRIO != 0) ? 1'b0 : ~r_ar_last;
    else                                     w_ar_sel = i_s1_ar_valid;
    w_aw_sel = 1'b0;
    if (r_aw_lock)                           w_aw_sel = r_aw_lock_idx;
    else if (i_s0_aw_valid && i_s1_aw_valid) w_aw_sel = (FIX_PRIO != 0) ? 1'b0 : ~r_aw_last;
    else                                     w_aw_sel = i_s1_aw_valid;
  end

  assign w_ar_valid    = w_ar_sel ? i_s1_ar_valid : i_s0_ar_valid;
  assign w_ar_hs       = w_ar_valid & i_m_ar_ready;
  assign o_m_ar_valid  = w_ar_valid;
  assign o_m_ar_id     = {w_ar_sel, (w_ar_sel ? i_s1_ar_id : i_s0_ar_id)};
  assign o_m_ar_addr   = w_ar_sel ? i_s1_ar_addr  : i_s0_ar_addr;
  assign o_m_ar_len    = w_ar_sel ? i_s1_ar_len   : i_s0_ar_len;
  assign o_m_ar_size   = w_ar_sel ? i_s1_ar_size  : i_s0_ar_size;
  assign o_m_ar_burst  = w_ar_sel ? i_s1_ar_burst : i_s0_ar_burst;
  assign o_s0_ar_ready = w_ar_hs & ~w_ar_sel;
  assign o_s1_ar_ready = w_ar_hs & w_ar_sel;

  // AW is held off entirely while the W-order FIFO is full (registered count)
  assign w_aw_ok       = (r_w_cnt != CNT_W'(MAX_W_TRANS));
  assign w_aw_valid    = w_aw_ok & (w_aw_sel ? i_s1_aw_valid : i_s0_aw_valid);
  assign w_aw_hs       = w_aw_valid & i_m_aw_ready;
  assign o_m_aw_valid  = w_aw_valid;
  assign o_m_aw_id     = {w_aw_sel, (w_aw_sel ? i_s1_aw_id : i_s0_aw_id)};
  assign o_m_aw_addr   = w_aw_sel ? i_s1_aw_addr  : i_s0_aw_addr;
  assign o_m_aw_len    = w_aw_sel ? i_s1_aw_len   : i_s0_aw_len;
  assign o_m_aw_size   = w_aw_sel ? i_s1_aw_size  : i_s0_aw_size;
  assign o_m_aw_burst  = w_aw_sel ? i_s1_aw_burst : i_s0_aw_burst;
  assign o_s0_aw_ready = w_aw_hs & ~w_aw_sel;
  assign o_s1_aw_ready = w_aw_hs & w_aw_sel;

  assign w_wq_nempty  = (r_w_cnt != '0);
  assign w_head       = r_wq[r_wq_rp];
  assign o_m_w_valid  = w_wq_nempty & (w_head ? i_s1_w_valid : i_s0_w_valid);
  assign o_m_w_data   = w_head ? i_s1_w_data : i_s0_w_data;
  assign o_m_w_strb   = w_head ? i_s1_w_strb : i_s0_w_strb;
  assign o_m_w_last   = w_head ? i_s1_w_last : i_s0_w_last;
  assign o_s0_w_ready = w_wq_nempty & ~w_head & i_m_w_ready;
  assign o_s1_w_ready = w_wq_nempty & w_head & i_m_w_ready;
  assign w_w_hs       = o_m_w_valid & i_m_w_ready;
  assign w_pop        = w_w_hs & o_m_w_last;

  // Responses steered by the master index carried in the ID MSB
  assign o_s0_b_valid = i_m_b_valid & ~i_m_b_id[4];
  assign o_s1_b_valid = i_m_b_valid & i_m_b_id[4];
  assign o_s0_b_id    = i_m_b_id[3:0];
  assign o_s1_b_id    = i_m_b_id[3:0];
  assign o_s0_b_resp  = i_m_b_resp;
  assign o_s1_b_resp  = i_m_b_resp;
  assign o_m_b_ready  = i_m_b_id[4] ? i_s1_b_ready : i_s0_b_ready;
  assign o_s0_r_valid = i_m_r_valid & ~i_m_r_id[4];
  assign o_s1_r_valid = i_m_r_valid & i_m_r_id[4];
  assign o_s0_r_id    = i_m_r_id[3:0];
  assign o_s1_r_id    = i_m_r_id[3:0];
  assign o_s0_r_data  = i_m_r_data;
  assign o_s1_r_data  = i_m_r_data;
  assign o_s0_r_resp  = i_m_r_resp;
  assign o_s1_r_resp  = i_m_r_resp;
  assign o_s0_r_last  = i_m_r_last;
  assign o_s1_r_last  = i_m_r_last;
  assign o_m_r_ready  = i_m_r_id[4] ? i_s1_r_ready : i_s0_r_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_lock     <= 1'b0;
      r_ar_lock_idx <= 1'b0;
      r_ar_last     <= 1'b1;
      r_aw_lock     <= 1'b0;
      r_aw_lock_idx <= 1'b0;
      r_aw_last     <= 1'b1;
      r_wq          <= '0;
      r_wq_wp       <= '0;
      r_wq_rp       <= '0;
      r_w_cnt       <= '0;
    end else begin
      r_ar_lock     <= w_ar_valid & ~i_m_ar_ready;
      r_ar_lock_idx <= w_ar_sel;
      if (w_ar_hs) r_ar_last <= w_ar_sel;
      r_aw_lock     <= w_aw_valid & ~i_m_aw_ready;
      r_aw_lock_idx <= w_aw_sel;
      if (w_aw_hs) begin
        r_aw_last        <= w_aw_sel;
        r_wq[r_wq_wp]    <= w_aw_sel;
        r_wq_wp          <= f_ptr_inc(r_wq_wp);
      end
      if (w_pop) r_wq_rp <= f_ptr_inc(r_wq_rp);
      if (w_aw_hs && !w_pop)      r_w_cnt <= r_w_cnt + CNT_W'(1);
      else if (!w_aw_hs && w_pop) r_w_cnt <= r_w_cnt - CNT_W'(1);
    end
  end

  a_ar_stable: assert property (@(posedge aclk) disable iff (!aresetn)
    (o_m_ar_valid && !i_m_ar_ready) |=> (o_m_ar_valid && $stable(o_m_ar_addr) && $stable(o_m_ar_id)));
  a_aw_stable: assert property (@(posedge aclk) disable iff (!aresetn)
    (o_m_aw_valid && !i_m_aw_ready) |=> (o_m_aw_valid && $stable(o_m_aw_addr) && $stable(o_m_aw_id)));
  a_cnt_max: assert property (@(posedge aclk) disable iff (!aresetn)
    r_w_cnt <= CNT_W'(MAX_W_TRANS));
  a_w_empty: assert property (@(posedge aclk) disable iff (!aresetn)
    o_m_w_valid |-> w_wq_nempty);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: response-routing vector table plus
// hand-written arbitration, grant-lock, W-ordering and FIFO-full sequences.
module tb_mem_port_arbiter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic        s0_ar_valid, s1_ar_valid, s0_aw_valid, s1_aw_valid;
  logic [3:0]  s0_ar_id, s1_ar_id, s0_aw_id, s1_aw_id;
  logic [31:0] s0_ar_addr, s1_ar_addr, s0_aw_addr, s1_aw_addr;
  logic [7:0]  s0_ar_len, s1_ar_len, s0_aw_len, s1_aw_len;
  logic [2:0]  s0_ar_size, s1_ar_size, s0_aw_size, s1_aw_size;
  logic [1:0]  s0_ar_burst, s1_ar_burst, s0_aw_burst, s1_aw_burst;
  logic        s0_w_valid, s1_w_valid, s0_w_last, s1_w_last;
  logic [31:0] s0_w_data, s1_w_data;
  logic [3:0]  s0_w_strb, s1_w_strb;
  logic        s0_b_ready, s1_b_ready, s0_r_ready, s1_r_ready;
  logic        m_ar_ready, m_aw_ready, m_w_ready, m_b_valid, m_r_valid, m_r_last;
  logic [4:0]  m_b_id, m_r_id;
  logic [1:0]  m_b_resp, m_r_resp;
  logic [31:0] m_r_data;

  logic        s0_ar_ready, s1_ar_ready, s0_aw_ready, s1_aw_ready, s0_w_ready, s1_w_ready;
  logic        s0_b_valid, s1_b_valid, s0_r_valid, s1_r_valid, s0_r_last, s1_r_last;
  logic [3:0]  s0_b_id, s1_b_id, s0_r_id, s1_r_id;
  logic [1:0]  s0_b_resp, s1_b_resp, s0_r_resp, s1_r_resp;
  logic [31:0] s0_r_data, s1_r_data;
  logic        m_ar_valid, m_aw_valid, m_w_valid, m_w_last, m_b_ready, m_r_ready;
  logic [4:0]  m_ar_id, m_aw_id;
  logic [31:0] m_ar_addr, m_aw_addr, m_w_data;
  logic [7:0]  m_ar_len, m_aw_len;
  logic [2:0]  m_ar_size, m_aw_size;
  logic [1:0]  m_ar_burst, m_aw_burst;
  logic [3:0]  m_w_strb;

  logic        f_s0_ar_ready, f_s1_ar_ready, f_s0_aw_ready, f_s1_aw_ready, f_s0_w_ready, f_s1_w_ready;
  logic        f_s0_b_valid, f_s1_b_valid, f_s0_r_valid, f_s1_r_valid, f_s0_r_last, f_s1_r_last;
  logic [3:0]  f_s0_b_id, f_s1_b_id, f_s0_r_id, f_s1_r_id;
  logic [1:0]  f_s0_b_resp, f_s1_b_resp, f_s0_r_resp, f_s1_r_resp;
  logic [31:0] f_s0_r_data, f_s1_r_data;
  logic        f_m_ar_valid, f_m_aw_valid, f_m_w_valid, f_m_w_last, f_m_b_ready, f_m_r_ready;
  logic [4:0]  f_m_ar_id, f_m_aw_id;
  logic [31:0] f_m_ar_addr, f_m_aw_addr, f_m_w_data;
  logic [7:0]  f_m_ar_len, f_m_aw_len;
  logic [2:0]  f_m_ar_size, f_m_aw_size;
  logic [1:0]  f_m_ar_burst, f_m_aw_burst;
  logic [3:0]  f_m_w_strb;

  mem_port_arbiter #(.MAX_W_TRANS(2), .FIX_PRIO(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_s0_ar_valid(s0_ar_valid), .o_s0_ar_ready(s0_ar_ready), .i_s0_ar_id(s0_ar_id), .i_s0_ar_addr(s0_ar_addr),
    .i_s0_ar_len(s0_ar_len), .i_s0_ar_size(s0_ar_size), .i_s0_ar_burst(s0_ar_burst),
    .i_s0_aw_valid(s0_aw_valid), .o_s0_aw_ready(s0_aw_ready), .i_s0_aw_id(s0_aw_id), .i_s0_aw_addr(s0_aw_addr),
    .i_s0_aw_len(s0_aw_len), .i_s0_aw_size(s0_aw_size), .i_s0_aw_burst(s0_aw_burst),
    .i_s0_w_valid(s0_w_valid), .o_s0_w_ready(s0_w_ready), .i_s0_w_data(s0_w_data), .i_s0_w_strb(s0_w_strb), .i_s0_w_last(s0_w_last),
    .o_s0_b_valid(s0_b_valid), .i_s0_b_ready(s0_b_ready), .o_s0_b_id(s0_b_id), .o_s0_b_resp(s0_b_resp),
    .o_s0_r_valid(s0_r_valid), .i_s0_r_ready(s0_r_ready), .o_s0_r_id(s0_r_id), .o_s0_r_data(s0_r_data),
    .o_s0_r_resp(s0_r_resp), .o_s0_r_last(s0_r_last),
    .i_s1_ar_valid(s1_ar_valid), .o_s1_ar_ready(s1_ar_ready), .i_s1_ar_id(s1_ar_id), .i_s1_ar_addr(s1_ar_addr),
    .i_s1_ar_len(s1_ar_len), .i_s1_ar_size(s1_ar_size), .i_s1_ar_burst(s1_ar_burst),
    .i_s1_aw_valid(s1_aw_valid), .o_s1_aw_ready(s1_aw_ready), .i_s1_aw_id(s1_aw_id), .i_s1_aw_addr(s1_aw_addr),
    .i_s1_aw_len(s1_aw_len), .i_s1_aw_size(s1_aw_size), .i_s1_aw_burst(s1_aw_burst),
    .i_s1_w_valid(s1_w_valid), .o_s1_w_ready(s1_w_ready), .i_s1_w_data(s1_w_data), .i_s1_w_strb(s1_w_strb), .i_s1_w_last(s1_w_last),
    .o_s1_b_valid(s1_b_valid), .i_s1_b_ready(s1_b_ready), .o_s1_b_id(s1_b_id), .o_s1_b_resp(s1_b_resp),
    .o_s1_r_valid(s1_r_valid), .i_s1_r_ready(s1_r_ready), .o_s1_r_id(s1_r_id), .o_s1_r_data(s1_r_data),
    .o_s1_r_resp(s1_r_resp), .o_s1_r_last(s1_r_last),
    .o_m_ar_valid(m_ar_valid), .i_m_ar_ready(m_ar_ready), .o_m_ar_id(m_ar_id), .o_m_ar_addr(m_ar_addr),
    .o_m_ar_len(m_ar_len), .o_m_ar_size(m_ar_size), .o_m_ar_burst(m_ar_burst),
    .o_m_aw_valid(m_aw_valid), .i_m_aw_ready(m_aw_ready), .o_m_aw_id(m_aw_id), .o_m_aw_addr(m_aw_addr),
    .o_m_aw_len(m_aw_len), .o_m_aw_size(m_aw_size), .o_m_aw_burst(m_aw_burst),
    .o_m_w_valid(m_w_valid), .i_m_w_ready(m_w_ready), .o_m_w_data(m_w_data), .o_m_w_strb(m_w_strb), .o_m_w_last(m_w_last),
    .i_m_b_valid(m_b_valid), .o_m_b_ready(m_b_ready), .i_m_b_id(m_b_id), .i_m_b_resp(m_b_resp),
    .i_m_r_valid(m_r_valid), .o_m_r_ready(m_r_ready), .i_m_r_id(m_r_id), .i_m_r_data(m_r_data),
    .i_m_r_resp(m_r_resp), .i_m_r_last(m_r_last)
  );

  mem_port_arbiter #(.MAX_W_TRANS(2), .FIX_PRIO(1)) dut_fix (
    .aclk(aclk), .aresetn(aresetn),
    .i_s0_ar_valid(s0_ar_valid), .o_s0_ar_ready(f_s0_ar_ready), .i_s0_ar_id(s0_ar_id), .i_s0_ar_addr(s0_ar_addr),
    .i_s0_ar_len(s0_ar_len), .i_s0_ar_size(s0_ar_size), .i_s0_ar_burst(s0_ar_burst),
    .i_s0_aw_valid(s0_aw_valid), .o_s0_aw_ready(f_s0_aw_ready), .i_s0_aw_id(s0_aw_id), .i_s0_aw_addr(s0_aw_addr),
    .i_s0_aw_len(s0_aw_len), .i_s0_aw_size(s0_aw_size), .i_s0_aw_burst(s0_aw_burst),
    .i_s0_w_valid(s0_w_valid), .o_s0_w_ready(f_s0_w_ready), .i_s0_w_data(s0_w_data), .i_s0_w_strb(s0_w_strb), .i_s0_w_last(s0_w_last),
    .o_s0_b_valid(f_s0_b_valid), .i_s0_b_ready(s0_b_ready), .o_s0_b_id(f_s0_b_id), .o_s0_b_resp(f_s0_b_resp),
    .o_s0_r_valid(f_s0_r_valid), .i_s0_r_ready(s0_r_ready), .o_s0_r_id(f_s0_r_id), .o_s0_r_data(f_s0_r_data),
    .o_s0_r_resp(f_s0_r_resp), .o_s0_r_last(f_s0_r_last),
    .i_s1_ar_valid(s1_ar_valid), .o_s1_ar_ready(f_s1_ar_ready), .i_s1_ar_id(s1_ar_id), .i_s1_ar_addr(s1_ar_addr),
    .i_s1_ar_len(s1_ar_len), .i_s1_ar_size(s1_ar_size), .i_s1_ar_burst(s1_ar_burst),
    .i_s1_aw_valid(s1_aw_valid), .o_s1_aw_ready(f_s1_aw_ready), .i_s1_aw_id(s1_aw_id), .i_s1_aw_addr(s1_aw_addr),
    .i_s1_aw_len(s1_aw_len), .i_s1_aw_size(s1_aw_size), .i_s1_aw_burst(s1_aw_burst),
    .i_s1_w_valid(s1_w_valid), .o_s1_w_ready(f_s1_w_ready), .i_s1_w_data(s1_w_data), .i_s1_w_strb(s1_w_strb), .i_s1_w_last(s1_w_last),
    .o_s1_b_valid(f_s1_b_valid), .i_s1_b_ready(s1_b_ready), .o_s1_b_id(f_s1_b_id), .o_s1_b_resp(f_s1_b_resp),
    .o_s1_r_valid(f_s1_r_valid), .i_s1_r_ready(s1_r_ready), .o_s1_r_id(f_s1_r_id), .o_s1_r_data(f_s1_r_data),
    .o_s1_r_resp(f_s1_r_resp), .o_s1_r_last(f_s1_r_last),
    .o_m_ar_valid(f_m_ar_valid), .i_m_ar_ready(m_ar_ready), .o_m_ar_id(f_m_ar_id), .o_m_ar_addr(f_m_ar_addr),
    .o_m_ar_len(f_m_ar_len), .o_m_ar_size(f_m_ar_size), .o_m_ar_burst(f_m_ar_burst),
    .o_m_aw_valid(f_m_aw_valid), .i_m_aw_ready(m_aw_ready), .o_m_aw_id(f_m_aw_id), .o_m_aw_addr(f_m_aw_addr),
    .o_m_aw_len(f_m_aw_len), .o_m_aw_size(f_m_aw_size), .o_m_aw_burst(f_m_aw_burst),
    .o_m_w_valid(f_m_w_valid), .i_m_w_ready(m_w_ready), .o_m_w_data(f_m_w_data), .o_m_w_strb(f_m_w_strb), .o_m_w_last(f_m_w_last),
    .i_m_b_valid(m_b_valid), .o_m_b_ready(f_m_b_ready), .i_m_b_id(m_b_id), .i_m_b_resp(m_b_resp),
    .i_m_r_valid(m_r_valid), .o_m_r_ready(f_m_r_ready), .i_m_r_id(m_r_id), .i_m_r_data(m_r_data),
    .i_m_r_resp(m_r_resp), .i_m_r_last(m_r_last)
  );

  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic init_inputs();
    {s0_ar_valid, s1_ar_valid, s0_aw_valid, s1_aw_valid} = '0;
    {s0_ar_id, s1_ar_id, s0_aw_id, s1_aw_id} = '0;
    {s0_ar_addr, s1_ar_addr, s0_aw_addr, s1_aw_addr} = '0;
    {s0_ar_len, s1_ar_len, s0_aw_len, s1_aw_len} = '0;
    {s0_ar_size, s1_ar_size, s0_aw_size, s1_aw_size} = '0;
    {s0_ar_burst, s1_ar_burst, s0_aw_burst, s1_aw_burst} = '0;
    {s0_w_valid, s1_w_valid, s0_w_last, s1_w_last} = '0;
    {s0_w_data, s1_w_data, s0_w_strb, s1_w_strb} = '0;
    {s0_b_ready, s1_b_ready, s0_r_ready, s1_r_ready} = '0;
    {m_ar_ready, m_aw_ready, m_w_ready, m_b_valid, m_r_valid, m_r_last} = '0;
    {m_b_id, m_r_id, m_b_resp, m_r_resp, m_r_data} = '0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1 aresetn = 1'b0;
    init_inputs();
    tick();
    aresetn = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       bv; logic [4:0] bid; logic br0, br1;
    logic       rv; logic [4:0] rid; logic rr0, rr1;
    logic       e_bv0, e_bv1, e_bready, e_rv0, e_rv1, e_rready;
  } rsp_vec_t;
  rsp_vec_t vt[5];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    vt[0] = '{1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 5'h1F, 1'b1, 1'b0, 1'b1, 5'h0A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'h15, 1'b0, 1'b1, 1'b1, 5'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 5'h07, 1'b1, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 5'h1F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state with downstream ready and slave W valid asserted
    aresetn = 1'b0;
    init_inputs();
    #2;
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    s0_w_valid = 1'b1; s1_w_valid = 1'b1;
    #1;
    chk("rst_m_ar_valid", 32'(m_ar_valid), 32'd0);
    chk("rst_m_aw_valid", 32'(m_aw_valid), 32'd0);
    chk("rst_m_w_valid", 32'(m_w_valid), 32'd0);
    chk("rst_s0_w_ready", 32'(s0_w_ready), 32'd0);
    chk("rst_s1_w_ready", 32'(s1_w_ready), 32'd0);
    chk("rst_s0_ar_ready", 32'(s0_ar_ready), 32'd0);
    chk("rst_s1_aw_ready", 32'(s1_aw_ready), 32'd0);
    chk("rst_s0_b_valid", 32'(s0_b_valid), 32'd0);
    chk("rst_s1_r_valid", 32'(s1_r_valid), 32'd0);
    chk("rst_m_b_ready", 32'(m_b_ready), 32'd0);
    init_inputs();
    tick();
    aresetn = 1'b1;
    #1;

    // Single read from port 0
    s0_ar_valid = 1'b1; s0_ar_id = 4'd3; s0_ar_addr = 32'h0000_1000; s0_ar_len = 8'd3;
    m_ar_ready = 1'b1;
    #1;
    chk("rd_m_ar_valid", 32'(m_ar_valid), 32'd1);
    chk("rd_m_ar_id", 32'(m_ar_id), 32'h03);
    chk("rd_m_ar_addr", m_ar_addr, 32'h0000_1000);
    chk("rd_m_ar_len", 32'(m_ar_len), 32'd3);
    chk("rd_s0_ar_ready", 32'(s0_ar_ready), 32'd1);
    chk("rd_s1_ar_ready", 32'(s1_ar_ready), 32'd0);
    tick();
    s0_ar_valid = 1'b0; s0_r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_id = 5'h03; m_r_data = 32'hD000_0000 + 32'(i); m_r_last = (i == 3);
      #1;
      chk("rd_s0_r_valid", 32'(s0_r_valid), 32'd1);
      chk("rd_s0_r_id", 32'(s0_r_id), 32'd3);
      chk("rd_s0_r_data", s0_r_data, 32'hD000_0000 + 32'(i));
      chk("rd_s0_r_last", 32'(s0_r_last), (i == 3) ? 32'd1 : 32'd0);
      chk("rd_s1_r_valid", 32'(s1_r_valid), 32'd0);
      chk("rd_m_r_ready", 32'(m_r_ready), 32'd1);
      tick();
    end
    init_inputs();

    // Response routing vectors
    for (int v = 0; v < 5; v++) begin
      m_b_valid = vt[v].bv; m_b_id = vt[v].bid; m_b_resp = 2'(v);
      s0_b_ready = vt[v].br0; s1_b_ready = vt[v].br1;
      m_r_valid = vt[v].rv; m_r_id = vt[v].rid;
      s0_r_ready = vt[v].rr0; s1_r_ready = vt[v].rr1;
      #1;
      chk($sformatf("vec%0d_s0_b_valid", v), 32'(s0_b_valid), 32'(vt[v].e_bv0));
      chk($sformatf("vec%0d_s1_b_valid", v), 32'(s1_b_valid), 32'(vt[v].e_bv1));
      chk($sformatf("vec%0d_m_b_ready", v), 32'(m_b_ready), 32'(vt[v].e_bready));
      chk($sformatf("vec%0d_s0_r_valid", v), 32'(s0_r_valid), 32'(vt[v].e_rv0));
      chk($sformatf("vec%0d_s1_r_valid", v), 32'(s1_r_valid), 32'(vt[v].e_rv1));
      chk($sformatf("vec%0d_m_r_ready", v), 32'(m_r_ready), 32'(vt[v].e_rready));
      chk($sformatf("vec%0d_b_id", v), 32'(vt[v].bid[4] ? s1_b_id : s0_b_id), 32'(vt[v].bid[3:0]));
      chk($sformatf("vec%0d_b_resp", v), 32'(s1_b_resp), 32'(v % 4));
      #1;
    end
    init_inputs();

    // Contended reads: round-robin vs fixed priority
    do_reset();
    s0_ar_valid = 1'b1; s0_ar_id = 4'h1; s0_ar_addr = 32'h100;
    s1_ar_valid = 1'b1; s1_ar_id = 4'h2; s1_ar_addr = 32'h200;
    m_ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(m_ar_id[4]), 32'(k % 2));
      chk($sformatf("rr_addr%0d", k), m_ar_addr, (k % 2 == 1) ? 32'h200 : 32'h100);
      chk($sformatf("fix_grant%0d", k), 32'(f_m_ar_id[4]), 32'd0);
      chk($sformatf("fix_s1_ready%0d", k), 32'(f_s1_ar_ready), 32'd0);
      tick();
    end
    init_inputs();

    // Grant lock while the memory side stalls AR
    do_reset();
    s1_ar_valid = 1'b1; s1_ar_id = 4'h7; s1_ar_addr = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        s0_ar_valid = 1'b1; s0_ar_id = 4'h4; s0_ar_addr = 32'h3000;
      end
      #1;
      chk($sformatf("lock_addr%0d", k), m_ar_addr, 32'h2000);
      chk($sformatf("lock_id%0d", k), 32'(m_ar_id), 32'h17);
      chk($sformatf("lock_s1_ready%0d", k), 32'(s1_ar_ready), 32'd0);
      tick();
    end
    m_ar_ready = 1'b1;
    #1;
    chk("lock_hs_addr", m_ar_addr, 32'h2000);
    chk("lock_hs_s1_ready", 32'(s1_ar_ready), 32'd1);
    chk("lock_hs_s0_ready", 32'(s0_ar_ready), 32'd0);
    tick();
    s1_ar_valid = 1'b0;
    #1;
    chk("lock_next_addr", m_ar_addr, 32'h3000);
    chk("lock_next_s0_ready", 32'(s0_ar_ready), 32'd1);
    tick();
    init_inputs();

    // W ordering follows AW acceptance order
    do_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    s1_aw_valid = 1'b1; s1_aw_id = 4'h2; s1_aw_len = 8'd1; s1_aw_addr = 32'h4000;
    #1;
    chk("wo_aw1_id", 32'(m_aw_id), 32'h12);
    chk("wo_aw1_ready", 32'(s1_aw_ready), 32'd1);
    tick();
    s1_aw_valid = 1'b0;
    s0_aw_valid = 1'b1; s0_aw_id = 4'h5; s0_aw_len = 8'd0; s0_aw_addr = 32'h5000;
    s0_w_valid = 1'b1; s0_w_data = 32'hA0A0; s0_w_last = 1'b1;
    #1;
    chk("wo_aw2_id", 32'(m_aw_id), 32'h05);
    chk("wo_aw2_ready", 32'(s0_aw_ready), 32'd1);
    chk("wo_s0_blocked", 32'(s0_w_ready), 32'd0);
    chk("wo_m_w_idle", 32'(m_w_valid), 32'd0);
    tick();
    s0_aw_valid = 1'b0;
    s1_w_valid = 1'b1; s1_w_data = 32'h1111; s1_w_last = 1'b0;
    #1;
    chk("wo_b0_valid", 32'(m_w_valid), 32'd1);
    chk("wo_b0_data", m_w_data, 32'h1111);
    chk("wo_b0_s1_ready", 32'(s1_w_ready), 32'd1);
    chk("wo_b0_s0_ready", 32'(s0_w_ready), 32'd0);
    tick();
    s1_w_data = 32'h2222; s1_w_last = 1'b1;
    #1;
    chk("wo_b1_data", m_w_data, 32'h2222);
    chk("wo_b1_last", 32'(m_w_last), 32'd1);
    chk("wo_b1_s0_ready", 32'(s0_w_ready), 32'd0);
    tick();
    s1_w_valid = 1'b0;
    #1;
    chk("wo_s0_ready", 32'(s0_w_ready), 32'd1);
    chk("wo_s0_data", m_w_data, 32'hA0A0);
    chk("wo_s1_ready", 32'(s1_w_ready), 32'd0);
    tick();
    #1;
    chk("wo_empty_w_valid", 32'(m_w_valid), 32'd0);
    chk("wo_empty_s0_ready", 32'(s0_w_ready), 32'd0);
    s0_w_valid = 1'b0;
    m_b_valid = 1'b1; m_b_id = 5'h12; s1_b_ready = 1'b1;
    #1;
    chk("wo_b_s1_valid", 32'(s1_b_valid), 32'd1);
    chk("wo_b_s1_id", 32'(s1_b_id), 32'h2);
    chk("wo_b_s0_valid", 32'(s0_b_valid), 32'd0);
    chk("wo_b_ready", 32'(m_b_ready), 32'd1);
    tick();
    init_inputs();

    // W FIFO full blocks AW; a pop frees it one cycle later
    do_reset();
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      s0_aw_valid = 1'b1; s0_aw_id = 4'(k); s0_aw_addr = 32'h100 * 32'(k);
      #1;
      chk($sformatf("full_aw%0d_ready", k), 32'(s0_aw_ready), 32'd1);
      tick();
    end
    s0_aw_id = 4'h3; s0_aw_addr = 32'h300;
    #1;
    chk("full_aw3_ready", 32'(s0_aw_ready), 32'd0);
    chk("full_aw3_m_valid", 32'(m_aw_valid), 32'd0);
    tick();
    s0_w_valid = 1'b1; s0_w_data = 32'hBEEF; s0_w_last = 1'b1;
    #1;
    chk("full_pop_w_ready", 32'(s0_w_ready), 32'd1);
    chk("full_pop_aw_ready", 32'(s0_aw_ready), 32'd0);
    tick();
    s0_w_valid = 1'b0;
    #1;
    chk("full_after_aw_ready", 32'(s0_aw_ready), 32'd1);
    chk("full_after_m_valid", 32'(m_aw_valid), 32'd1);
    chk("full_after_id", 32'(m_aw_id), 32'h03);
    tick();
    s0_aw_valid = 1'b0;
    s1_aw_valid = 1'b1; s1_aw_id = 4'h9;
    #1;
    chk("full_again_s1_ready", 32'(s1_aw_ready), 32'd0);
    tick();
    init_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single DDR memory AXI4 port (5-bit ID, 32-bit addr/data) between two 4-bit-ID masters.
- Port 0 is the CPU path from the peripheral demux. Port 1 is the SD-controller DMA master.
- AR and AW are arbitrated independently with round-robin priority. The master index is prepended to the ID, and W beats are ordered by a grant FIFO.
- B and R responses are routed back by the ID MSB.

Parameters:
- MAX_W_TRANS, 2: depth of the W-order FIFO, i.e. the maximum number of accepted AW whose W bursts have not yet completed (1..8).
- FIX_PRIO, 0: 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
- aclk  input  1  clock. All logic is on its rising edge.
- aresetn  input  1  reset, asynchronous assert, active-low. Drives all state to its reset value.
- slv0  AXI_BUS.Slave (ID 4, addr 32, data 32)  -  CPU memory requests.
- slv1  AXI_BUS.Slave (ID 4, addr 32, data 32)  -  SD DMA requests.
- mst  AXI_BUS.Master (ID 5, addr 32, data 32)  -  to memory controller.

Behaviour:
- Reset values:
  - mst ar_valid/aw_valid/w_valid/b_ready/r_ready = 0.
  - slvN ar_ready/aw_ready/w_ready = 0; slvN b_valid/r_valid = 0.
  - Round-robin pointers favour port 0; W FIFO empty.
- AR arbiter (combinational forward, zero added latency):
  - If no request is locked, pick among slvN.ar_valid: the sole requester, or on a tie the port not granted last (port 0 if FIX_PRIO=1).
  - mst.ar_* = winner's fields, with ar_id = {N, slvN.ar_id}. slvN.ar_ready = mst.ar_ready & grant_N.
  - Once mst.ar_valid is asserted without ready, the grant is locked until the handshake. No AXI valid drop, no field change.
  - Pointer updates only on handshake.
- AW arbiter: same rules as AR, plus:
  - Granting is also gated by W FIFO not full. When full, mst.aw_valid = 0 and both aw_ready = 0.
  - Each AW handshake pushes N into the W FIFO.
  - The full check uses the registered count. A pop in the same cycle does not unblock the push until the next cycle.
- W routing:
  - When the FIFO is non-empty, head H selects the source: mst.w_* = slvH.w_*, slvH.w_ready = mst.w_ready, and the other port's w_ready = 0.
  - When empty, mst.w_valid = 0 and both w_ready = 0.
  - A pushed entry is visible the cycle after its AW handshake, so W trails its AW by at least 1 cycle.
  - The FIFO pops on a W handshake with w_last = 1.
  - Simultaneous push and pop keeps the count unchanged and updates both pointers. Pointers wrap modulo MAX_W_TRANS.
- B routing:
  - N = mst.b_id[4]. slvN.b_valid = mst.b_valid; slvN.b_id = mst.b_id[3:0]; b_resp passes through.
  - mst.b_ready = slvN.b_ready. The other port sees b_valid = 0.
- R routing: same as B, using r_id[4]. r_data, r_resp and r_last pass through.
- No ordering between read and write channels is enforced; the memory controller handles it.
- Reset mid-burst: all state is cleared immediately. Outstanding transactions are discarded, and the system must reset downstream in the same cycle (shared aresetn).
- Assertions for the verifier:
  - mst.ar_valid and mst.aw_valid stable until ready.
  - W FIFO count ≤ MAX_W_TRANS.
  - No w_valid forwarded while the FIFO is empty.

Test Plan:
- Single read: slv0 AR addr 0x0000_1000, id 3, len 3; memory returns 4 beats with r_id 0x03 -> mst.ar_id = 0x03; slv0 sees 4 beats with id 3 and r_last on beat 4; slv1.r_valid stays 0.
- Contended reads, round-robin: both ports hold ar_valid for 4 handshakes, mst.ar_ready = 1 -> grant order 0,1,0,1; ar_id MSBs 0,1,0,1.
- Same contention with FIX_PRIO=1 -> grant order 0,0,0,0 while port 0 stays valid.
- Grant lock under backpressure: slv1 alone asserts AR, mst.ar_ready = 0 for 3 cycles, then slv0 asserts AR -> mst.ar_addr stays slv1's until the handshake; slv0 is granted next.
- W ordering: slv1 AW (len 1) then slv0 AW (len 0), W from slv0 presented first -> slv0.w_ready = 0 until both slv1 beats pass with w_last; then slv0's beat passes; slv1 gets B with b_id 0x1x, routed to slv1.
- FIFO full, MAX_W_TRANS=2: three AWs with W withheld -> third aw_ready = 0. Complete the first W burst (pop) -> third AW is accepted the following cycle.
